// File: rtl/key_event_ctrl_pkg.sv
// Shared PS/2 scan-code byte constants, decoder state encodings and event payload.
package key_event_ctrl_pkg;

   localparam logic [7:0] KB_E0 = 8'hE0;
   localparam logic [7:0] KB_F0 = 8'hF0;
   localparam logic [7:0] KB_FA = 8'hFA;
   localparam logic [7:0] KB_AA = 8'hAA;
   localparam logic [7:0] KB_FE = 8'hFE;
   localparam logic [7:0] KB_EE = 8'hEE;
   localparam logic [7:0] KB_00 = 8'h00;
   localparam logic [7:0] KB_FF = 8'hFF;

   localparam int unsigned EVT_W = 10;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_E0   = 2'b01,
      S_F0   = 2'b10,
      S_E0F0 = 2'b11
   } state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       brk;
      logic       ext;
   } evt_t;

   // Keyboard status/ack bytes that never start a key event.
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == KB_FA) || (b == KB_AA) || (b == KB_FE) ||
             (b == KB_EE) || (b == KB_00) || (b == KB_FF);
   endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Circular event buffer; a push into a full buffer is accepted only when a pop
// happens in the same cycle.
module key_evt_fifo
   import key_event_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = EVT_W
) (
   input  logic              Clk_F,
   input  logic              Reset_F,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_rdata_c,
   output logic              o_full,
   output logic              o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  w_count_nxt;
   logic              w_do_push;
   logic              w_do_pop;

   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_rdata_c = r_mem[r_rd_ptr];

   always_comb begin
      w_count_nxt = r_count;
      if (w_do_push && !w_do_pop) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge Clk_F or posedge Reset_F) begin
      if (Reset_F) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         o_full   <= 1'b0;
         o_empty  <= 1'b1;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_nxt;
         o_full  <= (w_count_nxt == CNT_W'(DEPTH));
         o_empty <= (w_count_nxt == '0);
      end
   end

endmodule

// File: rtl/key_event_ctrl.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into make/break events with an
// inter-byte timeout, and queues events for a ready/valid consumer.
module key_event_ctrl
   import key_event_ctrl_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic       Clk_F,
   input  logic       Reset_F,
   input  logic [7:0] rx_byte,
   input  logic       rx_done,
   output logic [7:0] evt_code,
   output logic       evt_break,
   output logic       evt_ext,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic       overflow,
   input  logic       clr_ovf
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [TMO_W-1:0] r_tmo;
   logic [TMO_W-1:0] w_tmo_nxt;
   logic             w_push;
   evt_t             w_evt;
   evt_t             w_head;
   logic [EVT_W-1:0] w_rdata;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             r_ovf;

   always_ff @(posedge Clk_F or posedge Reset_F) begin
      if (Reset_F) begin
         r_state <= S_IDLE;
         r_tmo   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tmo   <= w_tmo_nxt;
      end
   end

   // Decode on rx_done; otherwise count down the timeout while mid-sequence.
   always_comb begin
      w_state_nxt = r_state;
      w_tmo_nxt   = r_tmo;
      w_push      = 1'b0;
      w_evt       = '0;
      if (rx_done) begin
         case (r_state)
            S_IDLE: begin
               if (rx_byte == KB_E0) begin
                  w_state_nxt = S_E0;
               end else if (rx_byte == KB_F0) begin
                  w_state_nxt = S_F0;
               end else if (!is_ignored(rx_byte)) begin
                  w_push = 1'b1;
                  w_evt  = {rx_byte, 1'b0, 1'b0};
               end
            end
            S_E0: begin
               if (rx_byte == KB_F0) begin
                  w_state_nxt = S_E0F0;
               end else if (rx_byte != KB_E0) begin
                  w_push      = 1'b1;
                  w_evt       = {rx_byte, 1'b0, 1'b1};
                  w_state_nxt = S_IDLE;
               end
            end
            S_F0: begin
               if (rx_byte == KB_E0) begin
                  w_state_nxt = S_E0F0;
               end else if (rx_byte != KB_F0) begin
                  w_push      = 1'b1;
                  w_evt       = {rx_byte, 1'b1, 1'b0};
                  w_state_nxt = S_IDLE;
               end
            end
            S_E0F0: begin
               if ((rx_byte != KB_F0) && (rx_byte != KB_E0)) begin
                  w_push      = 1'b1;
                  w_evt       = {rx_byte, 1'b1, 1'b1};
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
         w_tmo_nxt = (w_state_nxt == S_IDLE) ? '0 : TMO_W'(TIMEOUT_CYC);
      end else if (r_state != S_IDLE) begin
         if (r_tmo <= TMO_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_tmo_nxt   = '0;
         end else begin
            w_tmo_nxt = r_tmo - TMO_W'(1);
         end
      end else begin
         w_tmo_nxt = '0;
      end
   end

   assign w_pop = evt_valid && evt_ready;

   key_evt_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (EVT_W)
   ) u_fifo (
      .Clk_F     (Clk_F),
      .Reset_F   (Reset_F),
      .i_push    (w_push),
      .i_wdata   (w_evt),
      .i_pop     (w_pop),
      .o_rdata_c (w_rdata),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   // Sticky drop flag; a new drop outranks a same-cycle clear.
   always_ff @(posedge Clk_F or posedge Reset_F) begin
      if (Reset_F) begin
         r_ovf <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
         r_ovf <= 1'b1;
      end else if (clr_ovf) begin
         r_ovf <= 1'b0;
      end
   end

   assign w_head    = evt_t'(w_rdata);
   assign evt_code  = w_head.code;
   assign evt_break = w_head.brk;
   assign evt_ext   = w_head.ext;
   assign evt_valid = !w_empty;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: decode sequences, FIFO full/overflow, timeout, reset.
module tb_key_event_ctrl;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 20;

   logic       Clk_F;
   logic       Reset_F;
   logic [7:0] rx_byte;
   logic       rx_done;
   logic [7:0] evt_code;
   logic       evt_break;
   logic       evt_ext;
   logic       evt_valid;
   logic       evt_ready;
   logic       overflow;
   logic       clr_ovf;

   int errors = 0;
   int checks = 0;
   logic [10:0] obs;
   logic [10:0] exp_v;

   key_event_ctrl #(
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .Clk_F     (Clk_F),
      .Reset_F   (Reset_F),
      .rx_byte   (rx_byte),
      .rx_done   (rx_done),
      .evt_code  (evt_code),
      .evt_break (evt_break),
      .evt_ext   (evt_ext),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   initial begin
      Clk_F = 1'b0;
      forever #5 Clk_F = ~Clk_F;
   end

   // Entered and left on a falling edge; the byte is taken on the rising edge between.
   task automatic send_byte(input logic [7:0] b);
      rx_byte = b;
      rx_done = 1'b1;
      @(negedge Clk_F);
      rx_done = 1'b0;
      rx_byte = 8'h00;
   endtask

   task automatic pop_one();
      evt_ready = 1'b1;
      @(negedge Clk_F);
      evt_ready = 1'b0;
   endtask

   task automatic test_reset();
      Reset_F = 1'b1;
      repeat (2) @(negedge Clk_F);
      obs   = {evt_valid, evt_code, evt_break, evt_ext};
      checks++;
      if (obs !== 11'h000) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=%h", obs, 11'h000);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_overflow got=%b exp=0", overflow);
      end
      Reset_F = 1'b0;
      evt_ready = 1'b1;
      repeat (2) @(negedge Clk_F);
      evt_ready = 1'b0;
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL empty_ready_ignored got=%b exp=0", evt_valid);
      end
   endtask

   task automatic test_make_break();
      evt_ready = 1'b1;
      send_byte(8'h1C);
      obs   = {evt_valid, evt_code, evt_break, evt_ext};
      exp_v = {1'b1, 8'h1C, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL mb_make got=%h exp=%h", obs, exp_v);
      end
      send_byte(8'hF0);
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL mb_gap_valid got=%b exp=0", evt_valid);
      end
      send_byte(8'h1C);
      obs   = {evt_valid, evt_code, evt_break, evt_ext};
      exp_v = {1'b1, 8'h1C, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL mb_break got=%h exp=%h", obs, exp_v);
      end
      @(negedge Clk_F);
      evt_ready = 1'b0;
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL mb_drained got=%b exp=0", evt_valid);
      end
   endtask

   task automatic test_extended();
      evt_ready = 1'b0;
      send_byte(8'hE0);
      send_byte(8'h75);
      obs   = {evt_valid, evt_code, evt_break, evt_ext};
      exp_v = {1'b1, 8'h75, 1'b0, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL ext_make got=%h exp=%h", obs, exp_v);
      end
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      obs = {evt_valid, evt_code, evt_break, evt_ext};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL ext_head_stable got=%h exp=%h", obs, exp_v);
      end
      pop_one();
      obs   = {evt_valid, evt_code, evt_break, evt_ext};
      exp_v = {1'b1, 8'h75, 1'b1, 1'b1};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL ext_break got=%h exp=%h", obs, exp_v);
      end
      pop_one();
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL ext_drained got=%b exp=0", evt_valid);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] codes [5];
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
      evt_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(codes[i]);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set got=%b exp=1", overflow);
      end
      clr_ovf = 1'b1;
      @(negedge Clk_F);
      clr_ovf = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear got=%b exp=0", overflow);
      end
      clr_ovf = 1'b1;
      send_byte(8'h2C);
      clr_ovf = 1'b0;
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set_beats_clr got=%b exp=1", overflow);
      end
      clr_ovf = 1'b1;
      @(negedge Clk_F);
      clr_ovf = 1'b0;
      obs   = {evt_valid, evt_code, evt_break, evt_ext};
      exp_v = {1'b1, 8'h15, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL ovf_head_kept got=%h exp=%h", obs, exp_v);
      end
   endtask

   // Entered with the buffer full of 15,1D,24,2D.
   task automatic test_back_to_back();
      logic [7:0] order [3];
      order = '{8'h24, 8'h2D, 8'h3C};
      evt_ready = 1'b1;
      send_byte(8'h3C);
      evt_ready = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_ovf got=%b exp=0", overflow);
      end
      obs   = {evt_valid, evt_code, evt_break, evt_ext};
      exp_v = {1'b1, 8'h1D, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL b2b_head got=%h exp=%h", obs, exp_v);
      end
      for (int i = 0; i < 3; i++) begin
         pop_one();
         obs   = {evt_valid, evt_code, evt_break, evt_ext};
         exp_v = {1'b1, order[i], 1'b0, 1'b0};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_order%0d got=%h exp=%h", i, obs, exp_v);
         end
      end
      pop_one();
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drained got=%b exp=0", evt_valid);
      end
   endtask

   task automatic test_timeout();
      evt_ready = 1'b0;
      send_byte(8'hF0);
      repeat (TMO) @(negedge Clk_F);
      send_byte(8'h1C);
      obs   = {evt_valid, evt_code, evt_break, evt_ext};
      exp_v = {1'b1, 8'h1C, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL tmo_expired got=%h exp=%h", obs, exp_v);
      end
      pop_one();
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL tmo_single_event got=%b exp=0", evt_valid);
      end
      send_byte(8'hF0);
      repeat (TMO - 1) @(negedge Clk_F);
      send_byte(8'h1C);
      obs   = {evt_valid, evt_code, evt_break, evt_ext};
      exp_v = {1'b1, 8'h1C, 1'b1, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL tmo_just_inside got=%h exp=%h", obs, exp_v);
      end
      pop_one();
   endtask

   task automatic test_ignored_and_reset();
      evt_ready = 1'b0;
      send_byte(8'hAA);
      send_byte(8'hFA);
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL ignored_bytes got=%b exp=0", evt_valid);
      end
      send_byte(8'hE0);
      Reset_F = 1'b1;
      @(negedge Clk_F);
      Reset_F = 1'b0;
      send_byte(8'h75);
      obs   = {evt_valid, evt_code, evt_break, evt_ext};
      exp_v = {1'b1, 8'h75, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_mid_seq got=%h exp=%h", obs, exp_v);
      end
   endtask

   initial begin
      Reset_F   = 1'b1;
      rx_byte   = 8'h00;
      rx_done   = 1'b0;
      evt_ready = 1'b0;
      clr_ovf   = 1'b0;
      test_reset();
      test_make_break();
      test_extended();
      test_overflow();
      test_back_to_back();
      test_timeout();
      test_ignored_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_event_ctrl.md
KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of buffered key events (power of two, at least 2).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 50000, meaning the Clk_F cycles allowed between bytes of one multi-byte code.
REQ-003 Clk_F  input  1  system clock; all state updates on the rising edge.
REQ-004 Reset_F  input  1  reset, asynchronous, active-high.
REQ-005 rx_byte  input  8  scan-code byte from the PS/2 receiver; valid only while rx_done=1.
REQ-006 rx_done  input  1  one-cycle strobe marking a new rx_byte.
REQ-007 evt_code  output  8  scan code of the head event.
REQ-008 evt_break  output  1  1 = key release, 0 = key press, for the head event.
REQ-009 evt_ext  output  1  1 = the head event used the E0 extended prefix.
REQ-010 evt_valid  output  1  the FIFO is not empty; the head event is presented.
REQ-011 evt_ready  input  1  consumer accept; a pop occurs when evt_valid and evt_ready are both 1.
REQ-012 overflow  output  1  sticky flag: an event was dropped.
REQ-013 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-014 Decoder FSM states SHALL be S_IDLE, S_E0, S_F0 and S_E0F0; the FSM SHALL advance only on cycles where rx_done=1, apart from the timeout in REQ-020.
REQ-015 S_IDLE: E0 SHALL go to S_E0; F0 SHALL go to S_F0; FA, AA, FE, EE, 00 and FF SHALL be ignored and stay in S_IDLE; any other byte SHALL push {code, break=0, ext=0} and stay in S_IDLE.
REQ-016 S_E0: F0 SHALL go to S_E0F0; E0 SHALL stay in S_E0; any other byte SHALL push {code, 0, 1} and go to S_IDLE.
REQ-017 S_F0: F0 SHALL stay in S_F0; E0 SHALL go to S_E0F0; any other byte SHALL push {code, 1, 0} and go to S_IDLE.
REQ-018 S_E0F0: F0 or E0 SHALL stay in S_E0F0; any other byte SHALL push {code, 1, 1} and go to S_IDLE.
REQ-019 Latency: a pushed event SHALL be visible on evt_* in the cycle after the rx_done edge that completes it, when the FIFO was empty.
REQ-020 Timeout: in any state other than S_IDLE, TIMEOUT_CYC consecutive cycles without rx_done SHALL return the FSM to S_IDLE with no push; the counter SHALL reload on every rx_done and SHALL hold at 0 while in S_IDLE.
REQ-021 FIFO: circular buffer of FIFO_DEPTH 10-bit entries, with log2(FIFO_DEPTH)-bit read/write pointers wrapping modulo the depth and a log2(FIFO_DEPTH)+1-bit count.
REQ-022 Full with push and no pop: the event SHALL be dropped, overflow SHALL be set, and the FIFO contents SHALL be unchanged.
REQ-023 Full with push and pop in the same cycle: both SHALL be performed, the count SHALL be unchanged, and no overflow SHALL occur.
REQ-024 Empty: a pop SHALL NOT be possible because evt_valid=0; evt_ready SHALL be ignored.
REQ-025 evt_code, evt_break and evt_ext SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-026 Overflow set and clr_ovf in the same cycle: set SHALL win.

Reset
REQ-027 Reset_F=1 SHALL asynchronously force: FSM to S_IDLE; pointers, count and timeout counter to 0; evt_valid=0; overflow=0; evt_code=8'h00; evt_break=0; evt_ext=0.
REQ-028 Reset asserted mid-sequence (e.g. after E0) SHALL discard the partial code, so no event is emitted for it after release.

Structure
REQ-029 A shared include file SHALL hold the byte constants (E0, F0, FA, AA, FE, EE, 00, FF) and the FSM state encodings; the encodings are 2 bits, binary.
REQ-030 The buffer SHALL be the sub-module key_evt_fifo (parameterised depth, 10-bit data, push/pop/full/empty); the decoder FSM and timeout logic SHALL reside in key_event_ctrl.

Verification
REQ-031 The bench SHALL cover: bytes 1C, F0, 1C with evt_ready=1 -> events {1C,0,0} then {1C,1,0}, and evt_valid low between them.
REQ-032 The bench SHALL cover: bytes E0, 75, E0, F0, 75 -> events {75,0,1} then {75,1,1}.
REQ-033 The bench SHALL cover: evt_ready=0 with 5 make codes 15, 1D, 24, 2D, 2C (depth 4) -> the first four are retained in order, 2C is dropped, and overflow=1; then clr_ovf -> overflow=0.
REQ-034 The bench SHALL cover: FIFO full, new code 3C pushed while evt_ready=1 in the same cycle -> no overflow, and the order continues 1D, 24, 2D, 3C.
REQ-035 The bench SHALL cover: byte F0, then TIMEOUT_CYC idle cycles, then byte 1C -> a single event {1C,0,0} (break discarded).
REQ-036 The bench SHALL cover: bytes AA and FA in S_IDLE -> no event; and Reset_F pulsed after E0 then byte 75 -> event {75,0,0}.
